// File: rtl/multi_channel_ram_fifo_pkg.sv
`default_nettype none
// ==== multi_channel_ram_fifo_pkg : shared width helpers for the multi-channel FIFO (rev 1.0) ====
package multi_channel_ram_fifo_pkg;

  // Ceiling log2, never below 1 so a single channel still gets a 1-bit select.
  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int ch_width(input int ch_num);
    return log2(ch_num);
  endfunction

  function automatic int ptr_width(input int depth);
    return log2(depth);
  endfunction

  function automatic int addr_width(input int ch_num, input int depth);
    return log2(ch_num) + log2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_channel_ram_fifo_if.sv
`default_nettype none
// ==== multi_channel_ram_fifo_if : write/read/flush request and status bundle (rev 1.0) ====
interface multi_channel_ram_fifo_if
  import multi_channel_ram_fifo_pkg::*;
#(
  parameter int Dw     = 32,
  parameter int CH_NUM = 4
);
  localparam int CHw = ch_width(CH_NUM);

  logic              wr_en;
  logic [CHw-1:0]    wr_ch;
  logic [Dw-1:0]     din;
  logic              rd_en;
  logic [CHw-1:0]    rd_ch;
  logic [CH_NUM-1:0] flush;
  logic [Dw-1:0]     dout;
  logic              dout_valid;
  logic [CH_NUM-1:0] full;
  logic [CH_NUM-1:0] empty;
  logic              ovf_err;
  logic              udf_err;

  modport master (
    output wr_en, wr_ch, din, rd_en, rd_ch, flush,
    input  dout, dout_valid, full, empty, ovf_err, udf_err
  );

  modport slave (
    input  wr_en, wr_ch, din, rd_en, rd_ch, flush,
    output dout, dout_valid, full, empty, ovf_err, udf_err
  );
endinterface
`default_nettype wire

// File: rtl/multi_channel_ram_fifo_ram.sv
`default_nettype none
// ==== simple_dual_port_ram : one write port, one registered read port returning old data (rev 1.0) ====
module simple_dual_port_ram #(
  parameter int Dw         = 32,
  parameter int Aw         = 5,
  parameter     INITIAL_EN = "NO"
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          i_we,
  input  wire logic [Aw-1:0] i_waddr,
  input  wire logic [Dw-1:0] i_din,
  input  wire logic          i_re,
  input  wire logic [Aw-1:0] i_raddr,
  output logic      [Dw-1:0] o_dout
);
  localparam int WORDS = 1 << Aw;

  logic [Dw-1:0] r_mem [WORDS];
  logic [Dw-1:0] r_dout;
  logic [Dw-1:0] w_rd_word;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_din;
  end

  generate
    if (INITIAL_EN == "YES") begin : g_init
      // Words not written since reset read back as zero, emulating a pre-cleared array.
      logic [WORDS-1:0] r_written;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)    r_written <= '0;
        else if (i_we) r_written[i_waddr] <= 1'b1;
      end
      assign w_rd_word = r_written[i_raddr] ? r_mem[i_raddr] : '0;
    end else begin : g_noinit
      assign w_rd_word = r_mem[i_raddr];
    end
  endgenerate

  // Same-edge write to i_raddr is not visible here: the read sees the old word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    r_dout <= '0;
    else if (i_re) r_dout <= w_rd_word;
  end

  assign o_dout = r_dout;
endmodule
`default_nettype wire

// File: rtl/multi_channel_ram_fifo.sv
`default_nettype none
// ==== multi_channel_ram_fifo : CH_NUM independent FIFOs sharing one dual-port RAM (rev 1.0) ====
module multi_channel_ram_fifo
  import multi_channel_ram_fifo_pkg::*;
#(
  parameter int Dw         = 32,
  parameter int CH_NUM     = 4,
  parameter int DEPTH      = 8,
  parameter     INITIAL_EN = "NO"
) (
  input wire logic              clk,
  input wire logic              reset,
  multi_channel_ram_fifo_if.slave bus
);
  localparam int CHw     = ch_width(CH_NUM);
  localparam int PTRw    = ptr_width(DEPTH);
  localparam int Aw      = addr_width(CH_NUM, DEPTH);
  localparam int CH_SPAN = 1 << CHw;
  localparam logic [PTRw:0] c_full_cnt = (PTRw+1)'(DEPTH);

  // Status vectors padded to the full select range so any wr_ch/rd_ch indexes safely.
  logic [CH_SPAN-1:0] w_full_x;
  logic [CH_SPAN-1:0] w_empty_x;
  logic [CH_SPAN-1:0] w_flush_x;
  logic [PTRw-1:0]    w_wr_ptr_x [CH_SPAN];
  logic [PTRw-1:0]    w_rd_ptr_x [CH_SPAN];

  logic          w_wr_ch_ok, w_rd_ch_ok;
  logic          w_wr_acc, w_rd_acc;
  logic          w_ovf_set, w_udf_set;
  logic [Aw-1:0] w_waddr, w_raddr;
  logic          r_dout_valid, r_ovf_err, r_udf_err;

  assign w_wr_ch_ok = int'(bus.wr_ch) < CH_NUM;
  assign w_rd_ch_ok = int'(bus.rd_ch) < CH_NUM;

  assign w_rd_acc = bus.rd_en && w_rd_ch_ok && !w_flush_x[bus.rd_ch] && !w_empty_x[bus.rd_ch];
  // A full channel still takes a write when the same cycle pops its head.
  assign w_wr_acc = bus.wr_en && w_wr_ch_ok && !w_flush_x[bus.wr_ch] &&
                    (!w_full_x[bus.wr_ch] || (w_rd_acc && (bus.rd_ch == bus.wr_ch)));

  // Unused channel slots report flush=0, so out-of-range requests count as errors.
  assign w_ovf_set = bus.wr_en && !w_wr_acc && !w_flush_x[bus.wr_ch];
  assign w_udf_set = bus.rd_en && !w_rd_acc && !w_flush_x[bus.rd_ch];

  generate
    for (genvar c = 0; c < CH_SPAN; c++) begin : g_ch
      if (c < CH_NUM) begin : g_live
        logic [PTRw-1:0] r_wr_ptr, r_rd_ptr;
        logic [PTRw:0]   r_count;
        logic            w_wr_hit, w_rd_hit;

        assign w_wr_hit = w_wr_acc && (bus.wr_ch == CHw'(c));
        assign w_rd_hit = w_rd_acc && (bus.rd_ch == CHw'(c));

        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
          end else if (bus.flush[c]) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
          end else begin
            if (w_wr_hit) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_hit) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr_hit && !w_rd_hit)      r_count <= r_count + 1'b1;
            else if (!w_wr_hit && w_rd_hit) r_count <= r_count - 1'b1;
          end
        end

        assign w_full_x[c]   = (r_count == c_full_cnt);
        assign w_empty_x[c]  = (r_count == '0);
        assign w_flush_x[c]  = bus.flush[c];
        assign w_wr_ptr_x[c] = r_wr_ptr;
        assign w_rd_ptr_x[c] = r_rd_ptr;
      end else begin : g_unused
        assign w_full_x[c]   = 1'b1;
        assign w_empty_x[c]  = 1'b1;
        assign w_flush_x[c]  = 1'b0;
        assign w_wr_ptr_x[c] = '0;
        assign w_rd_ptr_x[c] = '0;
      end
    end
  endgenerate

  assign w_waddr = {bus.wr_ch, w_wr_ptr_x[bus.wr_ch]};
  assign w_raddr = {bus.rd_ch, w_rd_ptr_x[bus.rd_ch]};

  simple_dual_port_ram #(
    .Dw         (Dw),
    .Aw         (Aw),
    .INITIAL_EN (INITIAL_EN)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_wr_acc),
    .i_waddr (w_waddr),
    .i_din   (bus.din),
    .i_re    (w_rd_acc),
    .i_raddr (w_raddr),
    .o_dout  (bus.dout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dout_valid <= 1'b0;
      r_ovf_err    <= 1'b0;
      r_udf_err    <= 1'b0;
    end else begin
      r_dout_valid <= w_rd_acc;
      if (w_ovf_set) r_ovf_err <= 1'b1;
      if (w_udf_set) r_udf_err <= 1'b1;
    end
  end

  assign bus.dout_valid = r_dout_valid;
  assign bus.full       = w_full_x[CH_NUM-1:0];
  assign bus.empty      = w_empty_x[CH_NUM-1:0];
  assign bus.ovf_err    = r_ovf_err;
  assign bus.udf_err    = r_udf_err;
endmodule
`default_nettype wire
